out_serializer: RTL and testbench

OUT_SERIALIZER -- requirements
Module: out_serializer

---
 rtl/out_serializer.sv | 166 ++++++++++++++++
 tb/tb_out_serializer.sv | 335 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/out_serializer.sv
// out_serializer
//   Buffers whole pixel vectors (CHANNEL_NUM signed samples) in a small FIFO
//   and streams each pixel as BEATS = CHANNEL_NUM/LANE_NUM beats of LANE_NUM
//   channels with a valid/ready handshake. Beat, column and row counters
//   generate start-of-frame, end-of-line and end-of-frame markers.
//   FIFO_DEPTH must be a power of two, at least 2.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous active-high reset
//   vs_in          frame-start pulse: flushes FIFO and counters, clears overflow
//   data_in_valid  data_in carries one pixel vector this cycle
//   data_in        pixel vector, channel-indexed
//   out_ready      downstream accepts the current beat
//   out_valid      out_data holds a valid beat (FIFO not empty)
//   out_data       one beat: channels b*LANE_NUM .. b*LANE_NUM+LANE_NUM-1
//   out_sof        beat 0 of pixel (0,0)
//   out_eol        last beat of the last pixel in a row
//   out_eof        last beat of the last pixel of the frame
//   overflow       sticky: a pixel was dropped since the last vs_in
//   fifo_level     pixel vectors currently stored

module out_serializer #(
  parameter int CHANNEL_NUM = 128,
  parameter int DATA_WIDTH  = 16,
  parameter int LANE_NUM    = 32,
  parameter int FIFO_DEPTH  = 4,
  parameter int FM_WIDTH    = 28,
  parameter int FM_HEIGHT   = 28
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       vs_in,
  input  logic                                       data_in_valid,
  input  logic signed [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] data_in,
  input  logic                                       out_ready,
  output logic                                       out_valid,
  output logic signed [LANE_NUM-1:0][DATA_WIDTH-1:0] out_data,
  output logic                                       out_sof,
  output logic                                       out_eol,
  output logic                                       out_eof,
  output logic                                       overflow,
  output logic [$clog2(FIFO_DEPTH):0]                fifo_level
);

  localparam int BEATS = CHANNEL_NUM / LANE_NUM;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int LW    = AW + 1;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int CW    = (FM_WIDTH > 1) ? $clog2(FM_WIDTH) : 1;
  localparam int RW    = (FM_HEIGHT > 1) ? $clog2(FM_HEIGHT) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_next;

  logic [CHANNEL_NUM-1:0][DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [BW-1:0] beat;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic accept, last_beat, pop, full, wr;
  logic mem_we;
  logic [AW-1:0] mem_waddr;

  // Same bit layout as a pixel vector, viewed as BEATS groups of LANE_NUM
  // channels, so beat selection is a plain index.
  logic [BEATS-1:0][LANE_NUM-1:0][DATA_WIDTH-1:0] head_beats;

  assign head_beats = mem[rd_ptr];

  assign out_valid = (fifo_level != '0);
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign last_beat = (beat == BW'(BEATS - 1));

  // A vs_in cycle is a flush; nothing is consumed from the FIFO in it.
  assign accept = out_valid & out_ready & ~vs_in;
  assign pop    = accept & last_beat;

  // Normal-path write; a full FIFO still takes a pixel when the head leaves.
  assign wr = (state == RUN) & ~vs_in & data_in_valid & (~full | pop);

  // On vs_in the incoming pixel lands in slot 0 of the freshly flushed FIFO.
  assign mem_we    = vs_in ? data_in_valid : wr;
  assign mem_waddr = vs_in ? '0 : wr_ptr;

  always_comb begin
    out_data = '0;
    if (out_valid) out_data = head_beats[beat];
  end

  assign out_sof = out_valid & (beat == '0) & (col == '0) & (row == '0);
  assign out_eol = out_valid & last_beat & (col == CW'(FM_WIDTH - 1));
  assign out_eof = out_eol & (row == RW'(FM_HEIGHT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (vs_in) state_next = RUN;
      RUN: begin
        if (vs_in)                  state_next = RUN;
        else if (accept && out_eof) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pixel storage carries no reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= data_in;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      beat       <= '0;
      col        <= '0;
      row        <= '0;
      overflow   <= 1'b0;
    end else if (vs_in) begin
      rd_ptr   <= '0;
      beat     <= '0;
      col      <= '0;
      row      <= '0;
      overflow <= 1'b0;
      if (data_in_valid) begin
        wr_ptr     <= AW'(1);
        fifo_level <= LW'(1);
      end else begin
        wr_ptr     <= '0;
        fifo_level <= '0;
      end
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({wr, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase

      if (accept) beat <= last_beat ? '0 : beat + BW'(1);

      if (pop) begin
        if (col == CW'(FM_WIDTH - 1)) begin
          col <= '0;
          row <= (row == RW'(FM_HEIGHT - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end

      if ((state == RUN) && data_in_valid && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_out_serializer.sv
module tb_out_serializer;

  localparam int CH = 128;
  localparam int DW = 16;
  localparam int LN = 32;

  typedef logic [CH-1:0][DW-1:0] pix_t;
  typedef logic [LN-1:0][DW-1:0] beat_t;

  logic clk = 1'b0;
  logic rst;
  logic vs_in;
  logic data_in_valid;
  logic signed [CH-1:0][DW-1:0] data_in;
  logic out_ready;
  logic out_valid;
  logic signed [LN-1:0][DW-1:0] out_data;
  logic out_sof, out_eol, out_eof, overflow;
  logic [2:0] fifo_level;

  int checks = 0;
  int errors = 0;

  out_serializer dut (
    .clk(clk), .rst(rst), .vs_in(vs_in), .data_in_valid(data_in_valid),
    .data_in(data_in), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
    .out_eof(out_eof), .overflow(overflow), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic pix_t mk(input int base, input int step);
    pix_t r;
    for (int k = 0; k < CH; k++) r[k] = DW'(base + k * step);
    return r;
  endfunction

  function automatic pix_t fpix(input int p);
    return mk(p * 131 + 5, 3);
  endfunction

  function automatic beat_t beat_of(input pix_t px, input int b);
    beat_t r;
    for (int i = 0; i < LN; i++) r[i] = px[b * LN + i];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: valid=%b level=%0d ovf=%b, want 0 0 0", out_valid, fifo_level, overflow);
    end
    checks++;
    if ({out_sof, out_eol, out_eof} !== 3'b000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b data=%h, want 000 and zero", {out_sof, out_eol, out_eof}, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_basic();
    pix_t p0;
    p0 = mk(0, 1);
    out_ready = 1'b1;
    vs_in = 1'b1; data_in_valid = 1'b1; data_in = p0;
    tick();
    vs_in = 1'b0; data_in_valid = 1'b0;
    for (int b = 0; b < 4; b++) begin
      checks++;
      if (fifo_level !== 3'd1 || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL basic_level beat %0d: level=%0d valid=%b, want 1 1", b, fifo_level, out_valid);
      end
      checks++;
      if (out_data !== beat_of(p0, b)) begin
        errors++;
        $display("FAIL basic_data beat %0d: got %h want %h", b, out_data, beat_of(p0, b));
      end
      checks++;
      if (out_sof !== (b == 0)) begin
        errors++;
        $display("FAIL basic_sof beat %0d: got %b want %b", b, out_sof, (b == 0));
      end
      tick();
    end
    checks++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_drain: level=%0d valid=%b, want 0 0", fifo_level, out_valid);
    end
  endtask

  task automatic test_overflow();
    pix_t first;
    logic [2:0] exp_lvl;
    first = mk(1000, 1);
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      vs_in = (n == 0); data_in_valid = 1'b1; data_in = mk(1000 + n * 10, 1);
      tick();
      exp_lvl = (n < 4) ? 3'(n + 1) : 3'd4;
      checks++;
      if (fifo_level !== exp_lvl || overflow !== (n == 4)) begin
        errors++;
        $display("FAIL ovf_fill n=%0d: level=%0d ovf=%b, want %0d %b", n, fifo_level, overflow, exp_lvl, (n == 4));
      end
    end
    vs_in = 1'b0; data_in_valid = 1'b0;
    tick();
    checks++;
    if (out_data !== beat_of(first, 0) || out_sof !== 1'b1) begin
      errors++;
      $display("FAIL ovf_hold: data=%h sof=%b, want %h 1", out_data, out_sof, beat_of(first, 0));
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b want 1", overflow);
    end
    vs_in = 1'b1;
    tick();
    vs_in = 1'b0;
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL ovf_clear: ovf=%b level=%0d, want 0 0", overflow, fifo_level);
    end
  endtask

  task automatic test_full_pop();
    pix_t px [4];
    pix_t e;
    e = mk(3000, 1);
    out_ready = 1'b0;
    for (int n = 0; n < 4; n++) begin
      px[n] = mk(2000 + n * 200, 1);
      data_in_valid = 1'b1; data_in = px[n];
      tick();
    end
    data_in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4) begin
      errors++;
      $display("FAIL fullpop_fill: level=%0d want 4", fifo_level);
    end
    out_ready = 1'b1;
    repeat (3) tick();
    checks++;
    if (out_data !== beat_of(px[0], 3)) begin
      errors++;
      $display("FAIL fullpop_beat3: got %h want %h", out_data, beat_of(px[0], 3));
    end
    data_in_valid = 1'b1; data_in = e;
    tick();
    data_in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL fullpop_write: level=%0d ovf=%b, want 4 0", fifo_level, overflow);
    end
    checks++;
    if (out_data !== beat_of(px[1], 0)) begin
      errors++;
      $display("FAIL fullpop_next: got %h want %h", out_data, beat_of(px[1], 0));
    end
    repeat (12) tick();
    checks++;
    if (out_data !== beat_of(e, 0) || fifo_level !== 3'd1) begin
      errors++;
      $display("FAIL fullpop_last: data=%h level=%0d, want %h 1", out_data, fifo_level, beat_of(e, 0));
    end
    repeat (4) tick();
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL fullpop_drain: level=%0d want 0", fifo_level);
    end
  endtask

  task automatic test_frame();
    int fed, beats, eol_cnt, eof_cnt, sof_cnt, pidx, bb;
    beat_t exp_d;
    logic [2:0] exp_f;
    fed = 0; beats = 0; eol_cnt = 0; eof_cnt = 0; sof_cnt = 0;
    out_ready = 1'b0;
    vs_in = 1'b1; data_in_valid = 1'b1; data_in = fpix(0);
    fed = 1;
    tick();
    vs_in = 1'b0;
    for (int cyc = 0; cyc < 20000; cyc++) begin
      if (beats == 3136) break;
      out_ready = cyc[0];
      if (fed < 784 && fifo_level < 3'd4) begin
        data_in_valid = 1'b1; data_in = fpix(fed);
        fed++;
      end else begin
        data_in_valid = 1'b0;
      end
      if (out_valid && out_ready) begin
        pidx = beats / 4;
        bb = beats % 4;
        exp_d = beat_of(fpix(pidx), bb);
        exp_f = {(bb == 0 && pidx == 0), (bb == 3 && (pidx % 28) == 27), (bb == 3 && pidx == 783)};
        checks++;
        if (out_data !== exp_d) begin
          errors++;
          $display("FAIL frame_data beat %0d: got %h want %h", beats + 1, out_data, exp_d);
        end
        checks++;
        if ({out_sof, out_eol, out_eof} !== exp_f) begin
          errors++;
          $display("FAIL frame_flags beat %0d: got %b want %b", beats + 1, {out_sof, out_eol, out_eof}, exp_f);
        end
        sof_cnt += int'(out_sof);
        eol_cnt += int'(out_eol);
        eof_cnt += int'(out_eof);
        beats++;
      end
      tick();
    end
    data_in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (beats != 3136) begin
      errors++;
      $display("FAIL frame_beats: got %0d want 3136", beats);
    end
    checks++;
    if (eol_cnt != 28 || eof_cnt != 1 || sof_cnt != 1) begin
      errors++;
      $display("FAIL frame_counts: eol=%0d eof=%0d sof=%0d, want 28 1 1", eol_cnt, eof_cnt, sof_cnt);
    end
    checks++;
    if (overflow !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL frame_end: ovf=%b level=%0d, want 0 0", overflow, fifo_level);
    end
  endtask

  task automatic test_idle_write();
    out_ready = 1'b0;
    data_in_valid = 1'b1; data_in = mk(7, 1);
    repeat (3) tick();
    data_in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_write: level=%0d valid=%b, want 0 0", fifo_level, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    pix_t p0, pn;
    p0 = mk(4000, 1);
    pn = mk(5000, 1);
    out_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      vs_in = (n == 0); data_in_valid = 1'b1; data_in = mk(4000 + n * 100, 1);
      tick();
    end
    vs_in = 1'b0; data_in_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd3) begin
      errors++;
      $display("FAIL rstmid_fill: level=%0d want 3", fifo_level);
    end
    out_ready = 1'b1;
    repeat (2) tick();
    out_ready = 1'b0;
    checks++;
    if (out_data !== beat_of(p0, 2)) begin
      errors++;
      $display("FAIL rstmid_beat2: got %h want %h", out_data, beat_of(p0, 2));
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b level=%0d data=%h, want 0 0 zero", out_valid, fifo_level, out_data);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    data_in_valid = 1'b1; data_in = mk(9, 1);
    repeat (4) tick();
    data_in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fifo_level !== 3'd0) begin
      errors++;
      $display("FAIL rstmid_quiet: valid=%b level=%0d, want 0 0", out_valid, fifo_level);
    end
    vs_in = 1'b1; data_in_valid = 1'b1; data_in = pn;
    tick();
    vs_in = 1'b0; data_in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || out_sof !== 1'b1 || out_data !== beat_of(pn, 0)) begin
      errors++;
      $display("FAIL rstmid_restart: valid=%b sof=%b data=%h, want 1 1 %h", out_valid, out_sof, out_data, beat_of(pn, 0));
    end
  endtask

  initial begin
    rst = 1'b1;
    vs_in = 1'b0;
    data_in_valid = 1'b0;
    data_in = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_overflow();
    test_full_pop();
    test_frame();
    test_idle_write();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
